// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch path.
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Instruction-memory read port plus decode handshake seen by the fetch unit.
// master = fetch unit side, slave = memory/decode side.
interface rv32i_fetch_unit_if;
  logic                          o_imem_rd_en;
  logic [rv32i_pkg::XLEN-1:0]    o_imem_rd_addr;
  logic [rv32i_pkg::XLEN-1:0]    i_imem_rd_data;
  logic                          i_imem_rd_valid;
  logic                          o_valid;
  logic [rv32i_pkg::XLEN-1:0]    o_instr;
  logic [rv32i_pkg::XLEN-1:0]    o_pc;
  logic                          i_ready;

  modport master (
    output o_imem_rd_en, o_imem_rd_addr, o_valid, o_instr, o_pc,
    input  i_imem_rd_data, i_imem_rd_valid, i_ready
  );
  modport slave (
    input  o_imem_rd_en, o_imem_rd_addr, o_valid, o_instr, o_pc,
    output i_imem_rd_data, i_imem_rd_valid, i_ready
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch unit: IDLE/REQ/HOLD FSM against a fixed-cadence memory.
// Define RV32I_FETCH_MISALIGN_EN to fault on misaligned redirect targets.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_redirect,
  input  logic [XLEN-1:0]      i_redirect_pc,
  output logic                 o_fault,
  rv32i_fetch_unit_if.master   bus
);

`ifdef RV32I_FETCH_MISALIGN_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_opc;
  logic [1:0]      r_stab;
  logic            r_valid;
  logic            r_fault;
  logic            r_lock;

  logic            w_redir_bad;
  logic            w_accept;
  logic [XLEN-1:0] w_redir_tgt;

  // With the feature off the low bits are simply dropped and no fault is raised.
  assign w_redir_bad = MISALIGN_EN & i_redirect & (|i_redirect_pc[1:0]);
  assign w_redir_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
  // Only a strobe seen after the address has been stable for two cycles is trusted.
  assign w_accept    = (r_state == REQ) & bus.i_imem_rd_valid & (r_stab >= 2'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_stab  <= 2'd0;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_opc   <= RESET_PC;
      r_fault <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_fault <= w_redir_bad;
      if (i_redirect) begin
        r_valid <= 1'b0;
        r_stab  <= 2'd0;
        if (w_redir_bad) begin
          r_lock  <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_lock  <= 1'b0;
          r_pc    <= w_redir_tgt;
          r_state <= i_en ? REQ : IDLE;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_stab <= 2'd0;
            if (i_en && !r_lock) r_state <= REQ;
          end
          REQ: begin
            if (!i_en) begin
              r_state <= IDLE;
            end else if (w_accept) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
              r_instr <= bus.i_imem_rd_data;
              r_opc   <= r_pc;
            end else if (r_stab != 2'd3) begin
              r_stab <= r_stab + 2'd1;
            end
          end
          HOLD: begin
            if (bus.i_ready) begin
              r_valid <= 1'b0;
              r_pc    <= r_pc + 32'd4;
              r_stab  <= 2'd0;
              r_state <= i_en ? REQ : IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_imem_rd_en   = (r_state == REQ);
  assign bus.o_imem_rd_addr = r_pc;
  assign bus.o_valid        = r_valid;
  assign bus.o_instr        = r_instr;
  assign bus.o_pc           = r_opc;
  assign o_fault            = r_fault;

endmodule
